fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Producer side of the execute-stage forwarding interface.
- Tracks the destinations of the instructions in the EX and MEM slots, compares them against the sources of the instruction in decode, and registers fwCntrlA/fwCntrlB so they are valid for the whole cycle that instruction spends in execute.
- Detects load-use hazards and inserts one-cycle bubbles.
- Sits alongside the ID/EX pipeline register and advances in lock-step with it.

Parameters:
- REG_AW, 3, register-specifier width (8 GPRs; r0 is a real register, not hard-wired to zero).
- WB_MEM, 2'b01, wbDataSel code meaning "result comes from memory" (load).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- extStall  in  1  whole-pipeline freeze (memory busy); all state holds
- flush  in  1  squash the instruction in decode (taken branch/jump resolved in EX)
- idValid  in  1  decode holds a real instruction
- rsD  in  REG_AW  decode source A specifier
- rtD  in  REG_AW  decode source B specifier
- rsUsedD  in  1  source A is read
- rtUsedD  in  1  source B is read (includes store data for ST/STU)
- regWrtD  in  1  decode instruction writes a register
- wrtRegD  in  REG_AW  decode destination
- wbDataSelD  in  2  decode write-back source: 00 addPC, 01 mem, 10 ALU, 11 imm8
- fwCntrlA  out  6  registered forwarding control for operand A
- fwCntrlB  out  6  registered forwarding control for operand B
- stall  out  1  combinational load-use stall: hold PC and IF/ID, bubble ID/EX

Behaviour:
- Control word format:
  - [5:4]=00 always.
  - [3]=forward enable.
  - [2]=0 for EX->EX, 1 for MEM->EX.
  - [1:0]=the write-back source code of the producing instruction.
  - [3]=0 means use the register-file value; the whole word is then 6'b000000.
- Internal slots: X{v,reg,sel} for the instruction now in EX, and M{v,reg,sel} for the instruction now in MEM.
- Match rules:
  - matchX(s) = X.v & regWrt-valid & X.reg==s.
  - matchM(s) is the same test against the M slot.
  - A source only matches when its used bit is set and idValid=1.
- Next control word per operand:
  - matchX: {2'b00,1,0,X.sel}.
  - else matchM: {2'b00,1,1,M.sel}.
  - else 0.
  - EX wins over MEM (younger producer).
- Load-use: stall = idValid & ~flush & (matchX(rs)|matchX(rt)) & X.sel==WB_MEM. Stall is combinational and is asserted regardless of extStall.
- Sequential update, in priority order:
  1. rst: X.v=0, M.v=0, fwCntrlA=fwCntrlB=0.
  2. extStall: hold all state.
  3. flush: M<=X. X<=bubble (v=0). fwCntrl<=0.
  4. stall: M<=X. X<=bubble. fwCntrl<=0.
  5. advance: M<=X. X<={idValid&regWrtD, wrtRegD, wbDataSelD}. fwCntrlA/B<=next words.
- Latency:
  - Hazard detection is combinational in decode.
  - Control words appear one cycle later, aligned with the instruction entering execute.
- After a load-use stall, the load sits in M, so the re-evaluated consumer gets MEM->EX from memory (6'b001101). A load never produces an EX->EX word with [1:0]=01.
- The W stage is not tracked; the register file's write-before-read bypass covers a 3-instruction distance.
- Both operands may match different slots, or the same slot, independently.
- Reset asserted mid-stall clears everything; stall then drops because X.v=0.

Optional Feature:
- Macro: FWD_HAZ_PERF_EN.
- Defined:
  - Adds outputs stallCnt[15:0] and fwdCnt[15:0].
  - stallCnt increments on each cycle with stall & ~extStall.
  - fwdCnt increments on each advance where either next word has [3]=1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD r1 (sel 10), then a consumer reading r1 on rs -> in the consumer's EX cycle fwCntrlA=6'b001010 and fwCntrlB=0.
- ADD r2, an unrelated instruction, then a consumer reading r2 on rt -> fwCntrlB=6'b001110.
- LD r3 (sel 01), then ADD reading r3 -> stall=1 for exactly one cycle, then the next word is 6'b001101. With FWD_HAZ_PERF_EN defined, stallCnt=1.
- r4 written by LBI (sel 11) two instructions back and by ADD one instruction back, consumer reads r4 on both rs and rt -> fwCntrlA=fwCntrlB=6'b001010 (EX wins).
- Load-use condition with flush=1 in the same cycle -> stall=0, X becomes a bubble, next words=0. Same scenario with extStall=1 for 3 cycles -> stall stays 1 and all state holds until release.
- rst asserted while stall=1 -> next cycle fwCntrlA=fwCntrlB=0 and stall=0.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Decode-side bundle for fwd_hazard_unit: decode operands in, forwarding controls and stall out.
// With FWD_HAZ_PERF_EN defined, the stallCnt/fwdCnt counter outputs are added.
interface fwd_hazard_if #(
    parameter int unsigned REG_AW = 3
);
    logic              extStall;
    logic              flush;
    logic              idValid;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic              rsUsedD;
    logic              rtUsedD;
    logic              regWrtD;
    logic [REG_AW-1:0] wrtRegD;
    logic [1:0]        wbDataSelD;
    logic [5:0]        fwCntrlA;
    logic [5:0]        fwCntrlB;
    logic              stall;
`ifdef FWD_HAZ_PERF_EN
    logic [15:0]       stallCnt;
    logic [15:0]       fwdCnt;
`endif

    modport master (
        output extStall, flush, idValid, rsD, rtD, rsUsedD, rtUsedD, regWrtD, wrtRegD,
               wbDataSelD,
        input  fwCntrlA, fwCntrlB, stall
`ifdef FWD_HAZ_PERF_EN
        , input stallCnt, fwdCnt
`endif
    );

    modport slave (
        input  extStall, flush, idValid, rsD, rtD, rsUsedD, rtUsedD, regWrtD, wrtRegD,
               wbDataSelD,
        output fwCntrlA, fwCntrlB, stall
`ifdef FWD_HAZ_PERF_EN
        , output stallCnt, fwdCnt
`endif
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM destinations, registers forwarding controls for the instruction entering EX,
// and raises a combinational load-use stall. FWD_HAZ_PERF_EN adds stall/forward counters.
module fwd_hazard_unit #(
    parameter int unsigned REG_AW = 3,
    parameter logic [1:0]  WB_MEM = 2'b01
) (
    input logic         clk,
    input logic         rst,
    fwd_hazard_if.slave hif
);
    logic              x_v_q, m_v_q;
    logic [REG_AW-1:0] x_reg_q, m_reg_q;
    logic [1:0]        x_sel_q, m_sel_q;
    logic [5:0]        fw_a_q, fw_b_q;
    logic [5:0]        fw_a_d, fw_b_d;
    logic              match_xa, match_xb, match_ma, match_mb;
    logic              stall, advance;

    always_comb begin
        match_xa = hif.idValid & hif.rsUsedD & x_v_q & (x_reg_q == hif.rsD);
        match_xb = hif.idValid & hif.rtUsedD & x_v_q & (x_reg_q == hif.rtD);
        match_ma = hif.idValid & hif.rsUsedD & m_v_q & (m_reg_q == hif.rsD);
        match_mb = hif.idValid & hif.rtUsedD & m_v_q & (m_reg_q == hif.rtD);

        stall   = hif.idValid & ~hif.flush & (match_xa | match_xb) & (x_sel_q == WB_MEM);
        advance = ~hif.extStall & ~hif.flush & ~stall;

        // EX holds the younger producer, so it takes priority over MEM.
        fw_a_d = 6'b000000;
        if (match_xa)      fw_a_d = {4'b0010, x_sel_q};
        else if (match_ma) fw_a_d = {4'b0011, m_sel_q};

        fw_b_d = 6'b000000;
        if (match_xb)      fw_b_d = {4'b0010, x_sel_q};
        else if (match_mb) fw_b_d = {4'b0011, m_sel_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_v_q   <= 1'b0;
            x_reg_q <= '0;
            x_sel_q <= 2'b00;
            m_v_q   <= 1'b0;
            m_reg_q <= '0;
            m_sel_q <= 2'b00;
            fw_a_q  <= 6'b000000;
            fw_b_q  <= 6'b000000;
        end else if (!hif.extStall) begin
            m_v_q   <= x_v_q;
            m_reg_q <= x_reg_q;
            m_sel_q <= x_sel_q;
            if (hif.flush || stall) begin
                x_v_q  <= 1'b0;
                fw_a_q <= 6'b000000;
                fw_b_q <= 6'b000000;
            end else begin
                x_v_q   <= hif.idValid & hif.regWrtD;
                x_reg_q <= hif.wrtRegD;
                x_sel_q <= hif.wbDataSelD;
                fw_a_q  <= fw_a_d;
                fw_b_q  <= fw_b_d;
            end
        end
    end

    assign hif.fwCntrlA = fw_a_q;
    assign hif.fwCntrlB = fw_b_q;
    assign hif.stall    = stall;

`ifdef FWD_HAZ_PERF_EN
    logic [15:0] stall_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
            fwd_cnt_q   <= 16'h0000;
        end else begin
            if (stall && !hif.extStall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (advance && (fw_a_d[3] || fw_b_d[3]) && fwd_cnt_q != 16'hFFFF) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
        end
    end

    assign hif.stallCnt = stall_cnt_q;
    assign hif.fwdCnt   = fwd_cnt_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif
endmodule
